sum_window_accumulator: RTL
===========================

Name: sum_window_accumulator

Overview:
- Downstream consumer of the top-level 8-bit operand adder (ui_in + uio_in).
- Takes the sum stream over a valid/ready handshake and accumulates a window of 1..2^LEN_W samples.
- Presents window total, window maximum and sample count as one held result with its own valid/ready handshake.
- Lets the tile report aggregate statistics over several adder results instead of a single combinational sum.

Parameters:
- DATA_W, 8, width of each input sample (adder output width).
- LEN_W, 4, width of win_len; window holds win_len+1 samples, max 2^LEN_W.
- SUM_W (localparam, derived), DATA_W+LEN_W = 12, accumulator width; guarantees no overflow.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; one clock; reset is synchronous and active-low
- clear  in  1  synchronous abort of current window/result
- win_len  in  LEN_W  window length minus one; sampled on first accept of a window
- in_data  in  DATA_W  sample (adder sum)
- in_valid  in  1  sample present
- in_ready  out  1  block accepts sample this cycle
- out_sum  out  SUM_W  window total
- out_max  out  DATA_W  largest sample in window (unsigned)
- out_count  out  LEN_W+1  samples in window (= win_len+1 latched)
- out_valid  out  1  result held
- out_ready  in  1  consumer takes result
- busy  out  1  high in ACCUM or OUTPUT

Behaviour:
- Reset (rst_n low at posedge): state IDLE; acc, max, cnt, len_q cleared; out_sum, out_max, out_count = 0; out_valid = 0; busy = 0.
- in_ready is forced 0 in any cycle where rst_n = 0.
- in_ready = (state != OUTPUT) && !clear && rst_n. Combinational from state, no dependency on in_valid.
- Accept = in_valid && in_ready. Data must be held by the upstream while in_valid is high and in_ready is low.
- IDLE, on accept:
  - len_q <= win_len; acc <= in_data; max <= in_data; cnt <= 1.
  - Next state is OUTPUT if win_len == 0, else ACCUM.
- ACCUM, on accept:
  - acc <= acc + in_data (zero-extended to SUM_W); max <= larger of max and in_data (unsigned); cnt <= cnt + 1.
  - If cnt == len_q (this accept is sample len_q+1), next state is OUTPUT.
- ACCUM with no accept: hold all state. Gaps in in_valid are allowed indefinitely.
- OUTPUT:
  - out_valid = 1. out_sum = acc, out_max = max, out_count = cnt, all registered and stable until the handshake.
  - On out_ready: next state IDLE, out_valid drops at the next edge.
  - in_ready = 0 throughout, so there is one bubble cycle before the next window.
- Latency: out_valid rises on the edge that registers the final accept. Result is visible in the cycle after the last sample handshake.
- out_* in IDLE/ACCUM hold the last delivered result (0 after reset). Consumers qualify with out_valid only.
- win_len changes after the first accept of a window are ignored until the next window.
- clear = 1 at posedge: state IDLE; acc, max, cnt = 0; out_valid = 0. Sample offered that cycle is not accepted.
- Priority: rst_n > clear > out handshake > in accept.
- Arithmetic: SUM_W cannot overflow, since max total = 2^LEN_W × (2^DATA_W − 1) = 4080. No saturation or wrap logic.
- out_ready while out_valid = 0 has no effect.

Decomposition:
- Shared package holds:
  - state enum {IDLE, ACCUM, OUTPUT} (2 bits);
  - DATA_W and LEN_W defaults;
  - SUM_W derivation function.
- No sub-module is natural; a single FSM plus datapath registers.
- Top level drives in_data from the adder sum and maps results onto uo_out/uio_out in a later change.

Test Plan:
- win_len=3; in 10, 20, 30, 40 back-to-back; out_ready=1 -> out_valid one cycle after 4th accept; out_sum=100, out_max=40, out_count=4; in_ready=0 for one cycle.
- win_len=15; sixteen samples of 255 -> out_sum=4080 (0xFF0), out_max=255, out_count=16; no wrap.
- win_len=0; in 7 -> out_sum=7, out_max=7, out_count=1 on next cycle; win_len changed to 5 mid-window in a 3-length run -> window still closes after 4 samples.
- Result held with out_ready=0 for 5 cycles, in_valid=1 throughout -> out_* stable, in_ready=0, no accepts; then out_ready=1 -> IDLE, in_ready=1 the following cycle.
- win_len=3; accept 50, 60; pulse clear; then 1, 2, 3, 4 -> out_sum=10, out_max=4 (no leftover 110); clear during OUTPUT drops out_valid next edge.
- rst_n low for 1 cycle during ACCUM and during OUTPUT -> all outputs 0 and busy=0 after that edge; in_ready=0 during reset cycle; normal window completes afterwards.

Source files
------------

// File: rtl/sum_window_accumulator_pkg.sv
// Shared types and sizing for the sum window accumulator.
//   swa_state_e      : FSM state encoding (IDLE, ACCUM, OUTPUT)
//   DEF_DATA_W/LEN_W : default sample and window-length widths
//   calc_sum_w()     : accumulator width wide enough that a full window never overflows
package sum_window_accumulator_pkg;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCUM  = 2'd1,
        OUTPUT = 2'd2
    } swa_state_e;

    // 2^len_w samples of at most 2^data_w-1 each fit in data_w+len_w bits
    function automatic int unsigned calc_sum_w(input int unsigned data_w, input int unsigned len_w);
        return data_w + len_w;
    endfunction

endpackage

// File: rtl/sum_window_accumulator.sv
// Accumulates a window of win_len+1 samples from the adder sum stream and
// presents total, maximum and sample count as one held result.
// Ports:
//   clk, rst_n       : clock, synchronous active-low reset
//   clear            : synchronous abort of the current window / result
//   win_len          : window length minus one, latched on the first accept of a window
//   in_data/in_valid/in_ready    : sample stream handshake (in_ready is combinational)
//   out_sum/out_max/out_count/out_valid/out_ready : held result handshake
//   busy             : high while a window is in progress or a result is held
module sum_window_accumulator
    import sum_window_accumulator_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned LEN_W  = DEF_LEN_W,
    localparam int unsigned SUM_W = calc_sum_w(DATA_W, LEN_W),
    localparam int unsigned CNT_W = LEN_W + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [LEN_W-1:0]  win_len,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [SUM_W-1:0]  out_sum,
    output logic [DATA_W-1:0] out_max,
    output logic [CNT_W-1:0]  out_count,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);

    swa_state_e        state_q, state_d;
    logic [SUM_W-1:0]  acc_q, acc_d;
    logic [DATA_W-1:0] max_q, max_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [SUM_W-1:0]  out_sum_q, out_sum_d;
    logic [DATA_W-1:0] out_max_q, out_max_d;
    logic [CNT_W-1:0]  out_count_q, out_count_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              accept;

    // Upstream may present a sample whenever no result is held and no abort/reset is pending
    assign in_ready = (state_q != OUTPUT) && !clear && rst_n;
    assign accept   = in_valid && in_ready;

    // Next-state and datapath
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        max_d       = max_q;
        cnt_d       = cnt_q;
        len_d       = len_q;
        out_sum_d   = out_sum_q;
        out_max_d   = out_max_q;
        out_count_d = out_count_q;

        if (clear) begin
            state_d = IDLE;
            acc_d   = '0;
            max_d   = '0;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (accept) begin
                        len_d   = win_len;
                        acc_d   = SUM_W'(in_data);
                        max_d   = in_data;
                        cnt_d   = CNT_W'(1);
                        state_d = (win_len == '0) ? OUTPUT : ACCUM;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc_d = acc_q + SUM_W'(in_data);
                        max_d = (in_data > max_q) ? in_data : max_q;
                        cnt_d = cnt_q + CNT_W'(1);
                        // cnt_q samples already taken; this one completes the window
                        if (cnt_q == CNT_W'(len_q)) begin
                            state_d = OUTPUT;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_ready) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Capture the result on entry to OUTPUT; it is then held until the next window closes
        if ((state_q != OUTPUT) && (state_d == OUTPUT)) begin
            out_sum_d   = acc_d;
            out_max_d   = max_d;
            out_count_d = cnt_d;
        end

        out_valid_d = (state_d == OUTPUT);
        busy_d      = (state_d != IDLE);
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            max_q       <= '0;
            cnt_q       <= '0;
            len_q       <= '0;
            out_sum_q   <= '0;
            out_max_q   <= '0;
            out_count_q <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            max_q       <= max_d;
            cnt_q       <= cnt_d;
            len_q       <= len_d;
            out_sum_q   <= out_sum_d;
            out_max_q   <= out_max_d;
            out_count_q <= out_count_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign out_sum   = out_sum_q;
    assign out_max   = out_max_q;
    assign out_count = out_count_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;

endmodule
